// File: rtl/counter_pkg.sv
// ---------------------------------------------------------------------------
// counter_pkg
// Shared definitions for the JK-based modulo counter:
//   mode_e  : counter operating modes (MODE input encoding)
//   jk_e    : JK flip-flop input codes, packed as {J, K}
//   jk_code : next-state to JK excitation for a single bit
// ---------------------------------------------------------------------------
package counter_pkg;

  typedef enum logic [1:0] {
    MODE_HOLD = 2'b00,
    MODE_UP   = 2'b01,
    MODE_DOWN = 2'b10,
    MODE_LOAD = 2'b11
  } mode_e;

  typedef enum logic [1:0] {
    JK_HOLD = 2'b00,
    JK_RST  = 2'b01,
    JK_SET  = 2'b10,
    JK_TGL  = 2'b11
  } jk_e;

  // Excitation that moves a cell from cur to next. Only set, reset or hold
  // are ever produced, so the toggle code never reaches a cell.
  function automatic jk_e jk_code(input logic next, input logic cur);
    return jk_e'({next & ~cur, ~next & cur});
  endfunction

endpackage

// File: rtl/jk_cell.sv
// ---------------------------------------------------------------------------
// jk_cell
// Single JK flip-flop with synchronous active-high reset.
//   clk_i : clock, rising edge
//   rst_i : synchronous reset, loads RST_VAL
//   j_i   : J input
//   k_i   : K input
//   q_o   : registered output
// {J,K}: 00 hold, 01 clear, 10 set, 11 toggle.
// ---------------------------------------------------------------------------
module jk_cell
  import counter_pkg::*;
#(
  parameter logic RST_VAL = 1'b0
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic j_i,
  input  logic k_i,
  output logic q_o
);

  logic q_q;

  // NOTE: state is updated with non-blocking assignments so every flop in the
  // design samples pre-edge values, independent of process ordering.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      q_q <= RST_VAL;
    end else begin
      case (jk_e'({j_i, k_i}))
        JK_HOLD: q_q <= q_q;
        JK_RST:  q_q <= 1'b0;
        JK_SET:  q_q <= 1'b1;
        JK_TGL:  q_q <= ~q_q;
        default: q_q <= q_q;
      endcase
    end
  end

  assign q_o = q_q;

endmodule

// File: rtl/jk_mod_counter.sv
// ---------------------------------------------------------------------------
// jk_mod_counter
// WIDTH-bit modulo-MODULUS counter built from JK cells, with hold, up, down
// and load modes plus a cascade terminal count.
//   CLK      : clock, rising edge
//   RST      : synchronous active-high reset (Q <= RESET_VALUE, ERR <= 0)
//   EN       : count enable; low forces hold
//   MODE     : 00 hold, 01 up, 10 down, 11 load
//   LOAD_VAL : value taken in load mode when below MODULUS
//   Q        : registered count, always < MODULUS
//   TC       : combinational terminal count, high in the cycle before a wrap
//   ERR      : sticky flag, set by an out-of-range load, cleared by RST
// ---------------------------------------------------------------------------
module jk_mod_counter
  import counter_pkg::*;
#(
  parameter int WIDTH       = 4,
  parameter int MODULUS     = 10,
  parameter int RESET_VALUE = 0
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             EN,
  input  logic [1:0]       MODE,
  input  logic [WIDTH-1:0] LOAD_VAL,
  output logic [WIDTH-1:0] Q,
  output logic             TC,
  output logic             ERR
);

  // Elaboration-time parameter legality.
  if (WIDTH < 1 || WIDTH > 16) begin : g_bad_width
    $fatal(1, "jk_mod_counter: WIDTH must be 1..16");
  end else if (MODULUS < 2 || MODULUS > (1 << WIDTH)) begin : g_bad_modulus
    $fatal(1, "jk_mod_counter: MODULUS must be 2..2**WIDTH");
  end else if (RESET_VALUE < 0 || RESET_VALUE >= MODULUS) begin : g_bad_reset
    $fatal(1, "jk_mod_counter: RESET_VALUE must be below MODULUS");
  end

  // Arithmetic runs one bit wider so MODULUS = 2**WIDTH is representable.
  localparam logic [WIDTH:0]   MOD_EXT = (WIDTH+1)'(MODULUS);
  localparam logic [WIDTH:0]   MOD_MAX = (WIDTH+1)'(MODULUS - 1);
  localparam logic [WIDTH:0]   ONE_EXT = (WIDTH+1)'(1);
  localparam logic [WIDTH:0]   ZER_EXT = '0;
  localparam logic [WIDTH-1:0] RST_VEC = WIDTH'(RESET_VALUE);

  mode_e            mode;
  logic [WIDTH:0]   q_ext;
  logic [WIDTH:0]   load_ext;
  logic [WIDTH:0]   next_ext;
  logic [WIDTH-1:0] next_d;
  logic [WIDTH-1:0] j_vec;
  logic [WIDTH-1:0] k_vec;
  logic             load_ok;
  logic             err_q;

  assign mode     = mode_e'(MODE);
  assign q_ext    = {1'b0, Q};
  assign load_ext = {1'b0, LOAD_VAL};
  assign load_ok  = (load_ext < MOD_EXT);

  // NOTE: next_ext gets a default before any branch so no path leaves it
  // unassigned, which would otherwise infer a latch.
  always_comb begin
    next_ext = q_ext;
    if (EN) begin
      unique case (mode)
        MODE_UP:   next_ext = (q_ext == MOD_MAX) ? ZER_EXT : q_ext + ONE_EXT;
        MODE_DOWN: next_ext = (q_ext == ZER_EXT) ? MOD_MAX : q_ext - ONE_EXT;
        MODE_LOAD: if (load_ok) next_ext = load_ext;
        default:   next_ext = q_ext;
      endcase
    end
  end

  assign next_d = next_ext[WIDTH-1:0];

  // Every entry path keeps the count inside the modulus.
  always_ff @(posedge CLK) begin
    if (!RST) begin
      assert (next_ext < MOD_EXT);
    end
  end

  // One JK cell per bit, excited to move from Q to next_d.
  for (genvar i = 0; i < WIDTH; i++) begin : g_bit
    jk_e code;
    assign code = jk_code(next_d[i], Q[i]);
    assign {j_vec[i], k_vec[i]} = code;

    jk_cell #(
      .RST_VAL(RST_VEC[i])
    ) u_cell (
      .clk_i(CLK),
      .rst_i(RST),
      .j_i  (j_vec[i]),
      .k_i  (k_vec[i]),
      .q_o  (Q[i])
    );
  end

  // Unregistered so a cascaded stage steps on the same edge as this wrap.
  assign TC = EN & (((mode == MODE_UP)   & (q_ext == MOD_MAX)) |
                    ((mode == MODE_DOWN) & (q_ext == ZER_EXT)));

  always_ff @(posedge CLK) begin
    if (RST) begin
      err_q <= 1'b0;
    end else if (EN && mode == MODE_LOAD && !load_ok) begin
      err_q <= 1'b1;
    end
  end

  assign ERR = err_q;

endmodule

// File: tb/tb_jk_mod_counter.sv
// ---------------------------------------------------------------------------
// tb_jk_mod_counter
// Three configurations driven side by side:
//   dut_a : WIDTH=4, MODULUS=10, RESET_VALUE=3
//   dut_b : WIDTH=4, MODULUS=16, RESET_VALUE=0 (full binary range)
//   units/tens : two MODULUS=10 stages cascaded through TC
// Expected values come from an integer model of the counting rules.
// ---------------------------------------------------------------------------
module tb_jk_mod_counter;

  logic       clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst, en;
  logic [1:0] mode;
  logic [3:0] load_val;
  logic [3:0] qa, qb;
  logic       tca, tcb, erra, errb;

  logic       rst_c, en_c;
  logic [1:0] mode_c;
  logic [3:0] zero_ld;
  logic [3:0] qu, qt;
  logic       tcu, tct, erru, errt;

  jk_mod_counter #(.WIDTH(4), .MODULUS(10), .RESET_VALUE(3)) dut_a (
    .CLK(clk), .RST(rst), .EN(en), .MODE(mode), .LOAD_VAL(load_val),
    .Q(qa), .TC(tca), .ERR(erra)
  );

  jk_mod_counter #(.WIDTH(4), .MODULUS(16), .RESET_VALUE(0)) dut_b (
    .CLK(clk), .RST(rst), .EN(en), .MODE(mode), .LOAD_VAL(load_val),
    .Q(qb), .TC(tcb), .ERR(errb)
  );

  jk_mod_counter #(.WIDTH(4), .MODULUS(10), .RESET_VALUE(0)) u_units (
    .CLK(clk), .RST(rst_c), .EN(en_c), .MODE(mode_c), .LOAD_VAL(zero_ld),
    .Q(qu), .TC(tcu), .ERR(erru)
  );

  jk_mod_counter #(.WIDTH(4), .MODULUS(10), .RESET_VALUE(0)) u_tens (
    .CLK(clk), .RST(rst_c), .EN(tcu), .MODE(mode_c), .LOAD_VAL(zero_ld),
    .Q(qt), .TC(tct), .ERR(errt)
  );

  int total = 0;
  int bad   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0d expected=%0d (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Reference model: plain integer arithmetic on the counting rules.
  int ma_q = 0, mb_q = 0, mc = 0;
  bit ma_err = 0, mb_err = 0;

  function automatic int model_next(int q, int m, int rv, bit r, bit e, int md, int ld);
    if (r)  return rv;
    if (!e) return q;
    case (md)
      1:       return (q + 1) % m;
      2:       return (q + m - 1) % m;
      3:       return (ld < m) ? ld : q;
      default: return q;
    endcase
  endfunction

  function automatic bit model_err(bit err, int m, bit r, bit e, int md, int ld);
    if (r) return 1'b0;
    if (e && md == 3 && ld >= m) return 1'b1;
    return err;
  endfunction

  function automatic bit model_tc(int q, int m, bit e, int md);
    return e && ((md == 1 && q == m - 1) || (md == 2 && q == 0));
  endfunction

  // One clock: check combinational TC mid-cycle, advance the model on the
  // edge, then check the registered outputs just after it.
  task automatic tick();
    @(negedge clk);
    check("tc_a",    tca, model_tc(ma_q, 10, en, int'(mode)));
    check("tc_b",    tcb, model_tc(mb_q, 16, en, int'(mode)));
    check("tc_unit", tcu, en_c && (mc % 10 == 9));
    check("tc_tens", tct, en_c && (mc == 99));
    @(posedge clk);
    ma_err = model_err(ma_err, 10, rst, en, int'(mode), int'(load_val));
    mb_err = model_err(mb_err, 16, rst, en, int'(mode), int'(load_val));
    ma_q   = model_next(ma_q, 10, 3, rst, en, int'(mode), int'(load_val));
    mb_q   = model_next(mb_q, 16, 0, rst, en, int'(mode), int'(load_val));
    if (rst_c)     mc = 0;
    else if (en_c) mc = (mc + 1) % 100;
    #1;
    check("q_a",   qa,   ma_q);
    check("err_a", erra, ma_err);
    check("q_b",   qb,   mb_q);
    check("err_b", errb, mb_err);
    check("units", qu,   mc % 10);
    check("tens",  qt,   mc / 10);
  endtask

  initial begin
    rst = 1'b1; en = 1'b0; mode = 2'b00; load_val = 4'd0;
    rst_c = 1'b1; en_c = 1'b0; mode_c = 2'b01; zero_ld = 4'd0;

    // Reset.
    tick();
    check("reset_q_a",   qa,   3);
    check("reset_err_a", erra, 0);
    rst = 1'b0; rst_c = 1'b0;

    // Cascade: 25 units steps while the other counters sit disabled.
    en_c = 1'b1;
    repeat (25) tick();
    en_c = 1'b0;
    check("cascade_tens",  qt, 2);
    check("cascade_units", qu, 5);

    // Up count from 3 through the wrap.
    en = 1'b1; mode = 2'b01;
    repeat (7) tick();
    check("up_wrap_a", qa, 0);

    // Load 0, then down through the wrap.
    mode = 2'b11; load_val = 4'd0;
    tick();
    mode = 2'b10;
    repeat (3) tick();
    check("down_a", qa, 7);

    // Out-of-range load, then a legal one; ERR stays set.
    mode = 2'b11; load_val = 4'd12;
    tick();
    check("badload_q_a",   qa,   7);
    check("badload_err_a", erra, 1);
    load_val = 4'd5;
    tick();
    check("goodload_q_a",   qa,   5);
    check("goodload_err_a", erra, 1);

    // Enable low, then explicit hold.
    en = 1'b0; mode = 2'b01;
    repeat (5) tick();
    en = 1'b1; mode = 2'b00;
    repeat (5) tick();
    check("hold_a", qa, 5);

    // Full binary range on dut_b: 15 -> 0 with TC at 15.
    mode = 2'b11; load_val = 4'd15;
    tick();
    mode = 2'b01;
    tick();
    check("full_wrap_b", qb, 0);

    // Reset clears the sticky flag.
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("err_cleared_a", erra, 0);

    // Randomized traffic against the model.
    for (int n = 0; n < 600; n++) begin
      rst      = ($urandom_range(0, 39) == 0);
      en       = ($urandom_range(0, 3) != 0);
      mode     = 2'($urandom_range(0, 3));
      load_val = 4'($urandom_range(0, 15));
      rst_c    = ($urandom_range(0, 199) == 0);
      en_c     = ($urandom_range(0, 4) != 0);
      tick();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/jk_mod_counter.md
# jk_mod_counter

Parametrised synchronous modulo counter built from an array of JK flip-flop cells, with up, down, load and hold modes. It generalises the single JK storage cell into a WIDTH-bit counter with a configurable modulus, a synchronous reset and a cascade-ready terminal-count output. It sits in the sequential-circuit lab designs as the standard counter for dividers, digit counters and cascaded multi-digit counters.

## Interface
- WIDTH, 4: counter width in bits; must be 1..16.
- MODULUS, 10: count range 0..MODULUS-1; must satisfy 2 ≤ MODULUS ≤ 2^WIDTH.
- RESET_VALUE, 0: value of Q after reset; must be < MODULUS.

- CLK  in  1  single clock; all state changes on the rising edge.
- RST  in  1  synchronous, active-high reset.
- EN  in  1  count enable. When low, the counter holds regardless of MODE.
- MODE  in  2  operating mode: 00 hold, 01 up, 10 down, 11 load.
- LOAD_VAL  in  WIDTH  value loaded when MODE=11.
- Q  out  WIDTH  counter value (registered).
- TC  out  1  terminal count (combinational; see Operation).
- ERR  out  1  sticky out-of-range-load flag (registered).

## Operation
- Reset: on a rising CLK edge with RST=1, Q becomes RESET_VALUE and ERR becomes 0. RST overrides EN and MODE.
- EN=0 or MODE=00: Q holds.
- MODE=01 (up): if Q=MODULUS-1, Q becomes 0; otherwise Q becomes Q+1.
- MODE=10 (down): if Q=0, Q becomes MODULUS-1; otherwise Q becomes Q-1.
- MODE=11 (load):
  - If LOAD_VAL < MODULUS, Q becomes LOAD_VAL.
  - Otherwise Q holds and ERR becomes 1. ERR stays at 1 until RST.
- TC = EN & ((MODE=01 & Q=MODULUS-1) | (MODE=10 & Q=0)).
  - TC is high only during the cycle before a wrap. It is intended to drive EN of the next cascaded stage.
  - TC is 0 in hold and load modes.
- Per-bit update:
  - next is the next-state value selected above.
  - Each bit i drives its cell with J_i = next_i & ~Q_i and K_i = ~next_i & Q_i.
  - The 11 (toggle) code is never issued. Hold is expressed as 00.
- Arithmetic: increment and decrement are done modulo MODULUS in WIDTH+1 bits. No intermediate value may overflow when MODULUS = 2^WIDTH.
- Out-of-range Q cannot occur: all entry paths (reset, wrap, load) keep Q < MODULUS.

## Timing
- Latency: 1 cycle. A mode or enable sampled at edge n is visible on Q after edge n.
- TC is combinational from Q, EN and MODE, with no register stage. Cascaded stages therefore step in the same edge as the wrapping stage.
- RST asserted mid-count takes effect at the next edge. The first counting step after RST is released occurs at the following edge.
- Simultaneous RST and MODE=11 with an out-of-range LOAD_VAL: reset wins and ERR stays 0.
- Changing MODE between cycles has no setup penalty. Every edge uses only the current inputs.

## Structure
- Sub-module jk_cell:
  - One JK flip-flop with synchronous active-high reset and a per-instance RST_VAL parameter.
  - 00 hold, 01 reset to 0, 10 set to 1, 11 toggle.
  - jk_mod_counter instantiates WIDTH cells in a generate loop.
- Shared package, counter_pkg:
  - MODE encodings MODE_HOLD, MODE_UP, MODE_DOWN, MODE_LOAD.
  - JK code constants JK_HOLD, JK_RST, JK_SET, JK_TGL.
- Parameter legality is checked at elaboration. An illegal WIDTH, MODULUS or RESET_VALUE is a fatal error.

## Test plan
- Reset value: with defaults, RESET_VALUE=3, assert RST for 1 edge. Q=3 and ERR=0. Then EN=1, MODE=01 for 7 edges: Q = 4,5,6,7,8,9,0, with TC=1 only while Q=9.
- Down wrap: defaults, load 0, then MODE=10 for 3 edges. Q = 9,8,7; TC=1 only in the cycle Q=0.
- Bad load: MODE=11, LOAD_VAL=12 with MODULUS=10. Q holds and ERR=1. Next, LOAD_VAL=5: Q=5 and ERR stays 1 until RST.
- Enable and hold: EN=0 with MODE=01 for 5 edges, then EN=1 with MODE=00 for 5 edges. Q is unchanged throughout and TC stays 0.
- Full range: WIDTH=4, MODULUS=16, counting up from 15. Q becomes 0 with no overflow, and TC=1 at Q=15.
- Cascade: two instances, the second's EN driven by the first's TC, both MODE=01, 25 edges from 00. The pair reads tens=2, units=5.
